down_counter_timer: RTL and testbench
=====================================

# down_counter_timer

Synchronous, loadable down counter with one-shot and auto-reload modes. It is the counting-down counterpart to the team's ripple up counter, intended as a general-purpose interval timer and delay generator. All flops share one clock edge, and an optional prescaler divides the count rate. Outputs give the count value, a one-cycle terminal-count pulse, and run/done status for a host FSM.

## Interface
- WIDTH, 4: counter width in bits (≥2).
- PRESCALE, 1: clk cycles per count step (≥1; 1 = decrement every cycle).

- clk  input  1  rising-edge clock, single domain.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  synchronous load strobe; captures load_val.
- load_val  input  WIDTH  initial/reload count.
- start  input  1  begin or resume counting.
- halt  input  1  pause counting; Q holds.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot.
- Q  output  WIDTH  current count (registered).
- tc  output  1  one-cycle terminal-count pulse (registered).
- busy  output  1  high in RUN.
- done  output  1  high in DONE.

## Operation
- Reset values: Q=0, reload_reg=0, state=IDLE, tc=0, busy=0, done=0, prescaler count=0. Reset takes effect immediately, with no clock edge needed, including mid-RUN.
- States: IDLE, RUN, DONE. busy and done decode directly from the state register.
- Input priority per edge: load > halt > start.
- load (any state): Q←load_val, reload_reg←load_val, state→IDLE, prescaler cleared, tc=0.
- halt in RUN: state→IDLE, Q holds, prescaler cleared. halt has no effect in IDLE or DONE.
- start in IDLE: if Q≠0, state→RUN; if Q=0, start is ignored.
- start in DONE: Q←reload_reg; state→RUN if reload_reg≠0, otherwise stays DONE.
- start in RUN: ignored.
- RUN, on prescaler tick:
  - Q>1: Q←Q−1.
  - Q=1, auto_reload=1: Q←reload_reg, tc=1, stay RUN.
  - Q=1, auto_reload=0: Q←0, tc=1, state→DONE.
- auto_reload is sampled at the tick where Q=1; it may change freely at other times.
- Q never underflows and never wraps below 0. In auto-reload mode Q never shows 0.
- tc is high only for the cycle after the tick that sets it.

## Timing
- Load latency: Q shows load_val one cycle after load is sampled.
- Prescaler restarts from 0 on every entry to RUN. The first tick occurs PRESCALE cycles after the edge that sampled start.
- Example with PRESCALE=1, load 5 at edge 0, start at edge 1:
  - Q=5 after edge 0; state=RUN after edge 1.
  - Q=4,3,2,1,0 after edges 2..6.
  - After edge 6: tc=1 and done=1; busy=0.
  - tc drops after edge 7.
- One-shot duration is load_val×PRESCALE cycles. Auto-reload period is reload_reg×PRESCALE cycles between tc pulses.
- halt freezes Q on the same edge that samples it; no further decrement occurs.

## Structure
- Shared package/header: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a clog2 helper for prescaler width.
- Sub-module tick_prescaler:
  - Parameter PRESCALE; ports clk, reset, clear, en, tick.
  - Internal counter 0..PRESCALE−1; tick is combinational, high when en and count=PRESCALE−1.
  - For PRESCALE=1, tick=en.
- Top level holds the FSM, Q, reload_reg and the tc register.

## Test plan
- Async reset: assert reset mid-RUN at Q=6 between clock edges → Q=0, busy=0, tc=0 immediately. After deassert, start is ignored while Q=0.
- One-shot: WIDTH=4, PRESCALE=1, load 5, start → Q steps 4,3,2,1,0 on consecutive cycles. tc is high exactly one cycle, coincident with Q=0. done=1 and busy=0 thereafter.
- Auto-reload: load 3, auto_reload=1, start → Q sequence 2,1,3,2,1,3,… with a tc pulse every 3 cycles, on each 1→3 step. Clear auto_reload → next 1→0 step enters DONE.
- Halt and restart:
  - Halt at Q=2 → Q holds 2, busy=0 for 10 cycles. Start → Q=1, then 0, with tc.
  - Start in DONE with reload_reg=4 → Q=4 and RUN.
- Priority: during RUN, load=1 (load_val=9), halt=1 and start=1 on the same edge → Q=9, state IDLE, tc=0.
- Prescaler: PRESCALE=4, load 2, start → Q=1 exactly 4 cycles after start, Q=0 and tc at 8 cycles, with no intermediate changes.

Source files
------------

// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down counter timer: FSM encodings and a
// ceiling-log2 helper used to size the prescaler counter.
package down_counter_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2; returns at least 1 so a counter is never zero bits wide.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((32'sd1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle between a host and the down counter timer.
interface down_counter_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             halt;
  logic             auto_reload;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             busy;
  logic             done;

  // Host side: issues commands, observes count and status.
  modport master (
    output load, load_val, start, halt, auto_reload,
    input  Q, tc, busy, done
  );

  // Timer side: receives commands, presents count and status.
  modport slave (
    input  load, load_val, start, halt, auto_reload,
    output Q, tc, busy, done
  );
endinterface

// File: rtl/down_counter_timer_tick_prescaler.sv
// Count-rate divider: emits a one-cycle tick every PRESCALE enabled cycles.
// With PRESCALE=1 the counter never leaves 0, so tick simply follows en.
module tick_prescaler
  import down_counter_timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);
  localparam int PW = clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // Next count: clear wins, otherwise wrap at LAST while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down counter with one-shot and auto-reload modes. Holds the
// IDLE/RUN/DONE FSM, the count, the reload value and the tc pulse register.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input logic clk,
  input logic reset,
  down_counter_timer_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             tick_s;
  logic             clear_s;

  // Prescaler restarts from zero whenever the timer is not actively running,
  // so every entry into RUN sees a full PRESCALE interval before the first step.
  assign clear_s = (state_q != RUN) | bus.load | bus.halt;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (clear_s),
    .en    (state_q == RUN),
    .tick  (tick_s)
  );

  // Next-state logic; load beats halt, halt beats start.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (bus.load) begin
      q_d      = bus.load_val;
      reload_d = bus.load_val;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.halt && bus.start && (q_q != '0)) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (bus.halt) begin
            state_d = IDLE;
          end else if (tick_s) begin
            if (q_q > ONE) begin
              q_d = q_q - ONE;
            end else if (bus.auto_reload) begin
              q_d  = reload_q;
              tc_d = 1'b1;
            end else begin
              q_d     = '0;
              tc_d    = 1'b1;
              state_d = DONE;
            end
          end else begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (!bus.halt && bus.start) begin
            q_d     = reload_q;
            state_d = (reload_q != '0) ? RUN : DONE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, count, reload and tc registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.tc   = tc_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed scoreboard bench: each stimulus cycle pushes the hand-computed
// outputs expected after the next clock edge; a monitor per DUT pops and
// compares shortly after every rising edge.
module tb_down_counter_timer;
  typedef struct packed {
    logic [3:0] q;
    logic       tc;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb1[$];
  exp_t sb4[$];

  down_counter_timer_if #(.WIDTH(4)) if1 ();
  down_counter_timer_if #(.WIDTH(4)) if4 ();

  down_counter_timer #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  down_counter_timer #(.WIDTH(4), .PRESCALE(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input exp_t act, input exp_t exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got Q=%0d tc=%0b busy=%0b done=%0b, want Q=%0d tc=%0b busy=%0b done=%0b",
               name, act.q, act.tc, act.busy, act.done, exp.q, exp.tc, exp.busy, exp.done);
    end
  endtask

  // Monitor for the PRESCALE=1 instance.
  always @(posedge clk) begin
    #2;
    if (sb1.size() != 0) begin
      compare("p1_cycle", {if1.Q, if1.tc, if1.busy, if1.done}, sb1.pop_front());
    end
  end

  // Monitor for the PRESCALE=4 instance.
  always @(posedge clk) begin
    #2;
    if (sb4.size() != 0) begin
      compare("p4_cycle", {if4.Q, if4.tc, if4.busy, if4.done}, sb4.pop_front());
    end
  end

  // One cycle on dut1: drive inputs, record expectation for after the next edge.
  task automatic cyc1(input logic ld, input logic [3:0] lv, input logic st, input logic hl,
                      input logic ar, input logic [3:0] eq, input logic etc,
                      input logic eb, input logic ed);
    if1.load = ld; if1.load_val = lv; if1.start = st; if1.halt = hl; if1.auto_reload = ar;
    sb1.push_back({eq, etc, eb, ed});
    @(negedge clk);
  endtask

  task automatic cyc4(input logic ld, input logic [3:0] lv, input logic st, input logic hl,
                      input logic ar, input logic [3:0] eq, input logic etc,
                      input logic eb, input logic ed);
    if4.load = ld; if4.load_val = lv; if4.start = st; if4.halt = hl; if4.auto_reload = ar;
    sb4.push_back({eq, etc, eb, ed});
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    if1.load = 1'b0; if1.load_val = 4'd0; if1.start = 1'b0; if1.halt = 1'b0; if1.auto_reload = 1'b0;
    if4.load = 1'b0; if4.load_val = 4'd0; if4.start = 1'b0; if4.halt = 1'b0; if4.auto_reload = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state persists with idle inputs.
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // One-shot: load 5, start, count 4..0, tc coincident with Q=0.
    cyc1(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
    cyc1(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Auto-reload: load 3, sequence 2,1,3,2,1,3 with tc on each 1->3 step.
    cyc1(1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    cyc1(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
    // Clear auto_reload: next 1->0 step enters DONE.
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Start in DONE reloads 3, then halt at Q=2 and hold for 10 cycles.
    cyc1(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    end
    cyc1(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);

    // Reload 4: run to DONE, then start in DONE gives Q=4 and RUN.
    cyc1(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
    cyc1(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    cyc1(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0);

    // Priority: load, halt and start together during RUN -> load wins.
    cyc1(1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);

    // Async reset mid-RUN at Q=6, applied between clock edges.
    cyc1(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0);
    cyc1(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    compare("async_reset", {if1.Q, if1.tc, if1.busy, if1.done}, {4'd0, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;
    // Start ignored while Q=0.
    cyc1(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc1(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Prescaler: PRESCALE=4, load 2, start -> step at +4, terminal at +8.
    cyc4(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    cyc4(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc4(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc4(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
    end
    cyc4(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    cyc4(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Drain scoreboards within a bounded number of cycles.
    for (int i = 0; i < 4 && (sb1.size() != 0 || sb4.size() != 0); i++) begin
      @(negedge clk);
    end
    checks = checks + 1;
    if (sb1.size() != 0 || sb4.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain: pending p1=%0d p4=%0d, want 0", sb1.size(), sb4.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
